// File: rtl/ob_gw.sv
// ob_gw: order gateway with ingress command FIFO, single-outstanding engine dispatch FSM and egress response FIFO
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   cmd_vld, cmd             command push into the ingress FIFO
//   cmd_full_r               registered back-pressure, asserted one entry before the FIFO is full
//   err_overflow_r           sticky: a command arrived while the ingress FIFO was full and was dropped
//   eng_vld, eng_cmd, eng_rdy  command offer handshake to the matching engine
//   eng_done, eng_reject     engine completion pulse and its reject qualifier
//   rsp_vld, rsp, rsp_accept egress FIFO head and pop
module ob_gw #(
    parameter int IN_N    = 8,
    parameter int OUT_N   = 4,
    parameter int UID_W   = 8,
    parameter int QTY_W   = 10,
    parameter int PRICE_W = 10,
    parameter int TIMEOUT = 64,
    localparam int CMD_W  = 2 + UID_W + QTY_W + PRICE_W,
    localparam int RSP_W  = 2 + UID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    input  logic [CMD_W-1:0] cmd,
    output logic             cmd_full_r,
    output logic             err_overflow_r,
    output logic             eng_vld,
    output logic [CMD_W-1:0] eng_cmd,
    input  logic             eng_rdy,
    input  logic             eng_done,
    input  logic             eng_reject,
    output logic             rsp_vld,
    output logic [RSP_W-1:0] rsp,
    input  logic             rsp_accept
);
    localparam int IA   = $clog2(IN_N);
    localparam int IC   = IA + 1;
    localparam int OA   = $clog2(OUT_N);
    localparam int OC   = OA + 1;
    localparam int TW   = $clog2(TIMEOUT);
    localparam int INM1 = IN_N - 1;
    localparam int TM1  = TIMEOUT - 1;
    localparam logic [IA:0]   IN_FULL  = IN_N[IA:0];
    localparam logic [IA:0]   IN_SKID  = INM1[IA:0];
    localparam logic [OA:0]   OUT_FULL = OUT_N[OA:0];
    localparam logic [TW-1:0] T_LAST   = TM1[TW-1:0];
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    localparam logic [1:0] ST_OK = 2'd0, ST_REJ = 2'd1, ST_NOP = 2'd2, ST_TO = 2'd3;
    localparam logic [1:0] OP_NOP = 2'd0, OP_CAN = 2'd3;

    logic [CMD_W-1:0] in_mem [IN_N];
    logic [IA-1:0]    in_wp, in_rp;
    logic [IA:0]      in_cnt, in_cnt_nxt;
    logic             in_push, in_pop;
    logic [CMD_W-1:0] head;
    logic [1:0]       head_op;
    logic             head_qty_zero;
    logic [RSP_W-1:0] out_mem [OUT_N];
    logic [OA-1:0]    out_wp, out_rp;
    logic [OA:0]      out_cnt;
    logic             out_push, out_pop;
    logic [1:0]       state, status;
    logic [CMD_W-1:0] hold;
    logic [TW-1:0]    timer;

    // a push at full is a drop even when the dispatcher pops in the same cycle
    assign in_push       = cmd_vld && in_cnt != IN_FULL;
    assign in_pop        = state == IDLE && in_cnt != '0;
    assign in_cnt_nxt    = in_cnt + IC'(in_push) - IC'(in_pop);
    assign head          = in_mem[in_rp];
    assign head_op       = head[CMD_W-1 -: 2];
    assign head_qty_zero = head[QTY_W+PRICE_W-1 -: QTY_W] == '0;

    assign eng_vld  = state == ISSUE;
    assign eng_cmd  = hold;
    assign out_push = state == RESP && out_cnt != OUT_FULL;
    assign out_pop  = rsp_vld && rsp_accept;
    assign rsp_vld  = out_cnt != '0;
    assign rsp      = out_mem[out_rp];

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wp] <= cmd;
        if (out_push) out_mem[out_wp] <= {status, hold[CMD_W-3 -: UID_W]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wp          <= '0;
            in_rp          <= '0;
            in_cnt         <= '0;
            cmd_full_r     <= 1'b0;
            err_overflow_r <= 1'b0;
        end else begin
            if (in_push) in_wp <= in_wp + IA'(1);
            if (in_pop) in_rp <= in_rp + IA'(1);
            in_cnt     <= in_cnt_nxt;
            cmd_full_r <= in_cnt_nxt >= IN_SKID;
            if (cmd_vld && !in_push) err_overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wp  <= '0;
            out_rp  <= '0;
            out_cnt <= '0;
        end else begin
            if (out_push) out_wp <= out_wp + OA'(1);
            if (out_pop) out_rp <= out_rp + OA'(1);
            out_cnt <= out_cnt + OC'(out_push) - OC'(out_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            status <= ST_OK;
            hold   <= '0;
            timer  <= '0;
        end else begin
            case (state)
                IDLE: if (in_pop) begin
                    hold <= head;
                    if (head_op == OP_NOP) begin
                        state  <= RESP;
                        status <= ST_NOP;
                    end else if (head_op != OP_CAN && head_qty_zero) begin
                        state  <= RESP;
                        status <= ST_REJ;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: if (eng_rdy) begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // a completion in the timeout cycle takes priority over the timeout
                    if (eng_done) begin
                        state  <= RESP;
                        status <= eng_reject ? ST_REJ : ST_OK;
                    end else if (timer == T_LAST) begin
                        state  <= RESP;
                        status <= ST_TO;
                    end
                end
                RESP: if (out_push) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ob_gw.sv
// tb_ob_gw: self-checking bench for ob_gw with a queue-based reference model, directed scenarios and randomized traffic
module tb_ob_gw;
    localparam int IN_N    = 8;
    localparam int OUT_N   = 4;
    localparam int UID_W   = 8;
    localparam int QTY_W   = 10;
    localparam int PRICE_W = 10;
    localparam int TIMEOUT = 16;
    localparam int CMD_W   = 2 + UID_W + QTY_W + PRICE_W;
    localparam int RSP_W   = 2 + UID_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_vld = 1'b0;
    logic [CMD_W-1:0] cmd = '0;
    logic             cmd_full_r, err_overflow_r, eng_vld, rsp_vld;
    logic [CMD_W-1:0] eng_cmd;
    logic             eng_rdy = 1'b0, eng_done = 1'b0, eng_reject = 1'b0, rsp_accept = 1'b0;
    logic [RSP_W-1:0] rsp;

    int errors = 0;
    int checks = 0;
    bit saw_eng, saw_rsp;
    int exp_uid [13] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 14, 18};

    always #5 clk = ~clk;

    ob_gw #(
        .IN_N(IN_N), .OUT_N(OUT_N), .UID_W(UID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .cmd_vld(cmd_vld), .cmd(cmd), .cmd_full_r(cmd_full_r),
        .err_overflow_r(err_overflow_r), .eng_vld(eng_vld), .eng_cmd(eng_cmd), .eng_rdy(eng_rdy),
        .eng_done(eng_done), .eng_reject(eng_reject), .rsp_vld(rsp_vld), .rsp(rsp), .rsp_accept(rsp_accept)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CMD_W-1:0] mk(input logic [1:0] op, input int uid, input int qty, input int price);
        return {op, UID_W'(uid), QTY_W'(qty), PRICE_W'(price)};
    endfunction

    // reference model: queues for both FIFOs plus the lifecycle of the one command in flight
    logic [CMD_W-1:0] in_q [$];
    logic [RSP_W-1:0] out_q [$];
    bit               m_busy, m_offer, m_wait, m_ready, m_ovf, m_full;
    logic [CMD_W-1:0] m_hold = '0;
    logic [1:0]       m_status = 2'd0;
    int               m_deadline, cyc;

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_busy = 0; m_offer = 0; m_wait = 0; m_ready = 0; m_ovf = 0; m_full = 0;
    endtask

    task automatic model_step();
        int isz = in_q.size();
        int osz = out_q.size();
        bit ipush = cmd_vld && isz < IN_N;
        bit ipop = !m_busy && isz > 0;
        bit opush = m_ready && osz < OUT_N;
        bit opop = osz > 0 && rsp_accept;
        logic [RSP_W-1:0] rword = {m_status, m_hold[CMD_W-3 -: UID_W]};
        logic [1:0] op;
        bit qz;
        if (cmd_vld && isz == IN_N) m_ovf = 1;
        if (opop) void'(out_q.pop_front());
        if (opush) begin
            out_q.push_back(rword);
            m_busy = 0;
            m_ready = 0;
        end else if (ipop) begin
            m_hold = in_q[0];
            op = m_hold[CMD_W-1 -: 2];
            qz = m_hold[QTY_W+PRICE_W-1 -: QTY_W] == '0;
            m_busy = 1;
            if (op == 2'd0) begin m_status = 2'd2; m_ready = 1; end
            else if (op != 2'd3 && qz) begin m_status = 2'd1; m_ready = 1; end
            else m_offer = 1;
        end else if (m_offer && eng_rdy) begin
            m_offer = 0;
            m_wait = 1;
            m_deadline = cyc + TIMEOUT;
        end else if (m_wait && (eng_done || cyc == m_deadline)) begin
            m_wait = 0;
            m_ready = 1;
            m_status = !eng_done ? 2'd3 : eng_reject ? 2'd1 : 2'd0;
        end
        if (ipop) void'(in_q.pop_front());
        if (ipush) in_q.push_back(cmd);
        m_full = in_q.size() >= IN_N - 1;
        cyc++;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("eng_vld", eng_vld, m_offer);
            if (m_offer) chk("eng_cmd", eng_cmd, m_hold);
            chk("rsp_vld", rsp_vld, out_q.size() != 0);
            if (out_q.size() != 0) chk("rsp", rsp, out_q[0]);
            chk("cmd_full_r", cmd_full_r, m_full);
            chk("err_overflow_r", err_overflow_r, m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (eng_vld === 1'b1) saw_eng = 1;
        if (rsp_vld === 1'b1) saw_rsp = 1;
    endtask

    task automatic push(input logic [CMD_W-1:0] c);
        cmd_vld = 1'b1;
        cmd = c;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_eng();
        int n = 0;
        while (eng_vld !== 1'b1 && n < 50) begin tick(); n++; end
        chk("wait_eng_vld", eng_vld, 1'b1);
    endtask

    task automatic get_rsp(output logic [RSP_W-1:0] r);
        int n = 0;
        while (rsp_vld !== 1'b1 && n < 200) begin tick(); n++; end
        chk("wait_rsp_vld", rsp_vld, 1'b1);
        r = rsp;
        rsp_accept = 1'b1;
        tick();
        rsp_accept = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [RSP_W-1:0] r;
        int n, first_full, rsp_cnt;
        repeat (3) tick();
        chk("reset_eng_vld", eng_vld, 1'b0);
        chk("reset_rsp_vld", rsp_vld, 1'b0);
        chk("reset_cmd_full_r", cmd_full_r, 1'b0);
        chk("reset_err_overflow_r", err_overflow_r, 1'b0);
        rst = 1'b1;
        tick();

        // NOP: response visible in the third cycle after the push cycle
        saw_eng = 0;
        push(mk(0, 'h11, 0, 0));
        chk("nop_cycle1_rsp_vld", rsp_vld, 1'b0);
        tick();
        chk("nop_cycle2_rsp_vld", rsp_vld, 1'b0);
        tick();
        chk("nop_cycle3_rsp_vld", rsp_vld, 1'b1);
        chk("nop_cycle3_rsp", rsp, {2'd2, 8'h11});
        rsp_accept = 1'b1;
        tick();
        rsp_accept = 1'b0;
        chk("nop_no_eng_vld", saw_eng, 1'b0);

        // BUY with zero quantity is rejected without engine involvement
        saw_eng = 0;
        push(mk(1, 'h22, 0, 5));
        get_rsp(r);
        chk("buy_qty0_rsp", r, {2'd1, 8'h22});
        chk("buy_qty0_no_eng_vld", saw_eng, 1'b0);

        // SELL with delayed eng_rdy, completion three cycles after accept
        push(mk(2, 'h33, 7, 9));
        wait_eng();
        repeat (5) begin
            chk("sell_eng_cmd_stable", eng_cmd, mk(2, 'h33, 7, 9));
            tick();
        end
        chk("sell_eng_vld_held", eng_vld, 1'b1);
        eng_rdy = 1'b1;
        tick();
        eng_rdy = 1'b0;
        chk("sell_eng_vld_dropped", eng_vld, 1'b0);
        tick();
        tick();
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        get_rsp(r);
        chk("sell_rsp", r, {2'd0, 8'h33});

        // BUY accepted but never completed: timeout decided TIMEOUT cycles after the accept
        push(mk(1, 'h44, 3, 1));
        wait_eng();
        eng_rdy = 1'b1;
        tick();
        eng_rdy = 1'b0;
        n = 0;
        while (rsp_vld !== 1'b1 && n < TIMEOUT + 10) begin tick(); n++; end
        chk("timeout_latency", n, TIMEOUT + 1);
        chk("timeout_rsp", rsp, {2'd3, 8'h44});
        rsp_accept = 1'b1;
        tick();
        rsp_accept = 1'b0;

        // completion arriving in the timeout cycle wins over the timeout
        push(mk(1, 'h45, 3, 1));
        wait_eng();
        eng_rdy = 1'b1;
        tick();
        eng_rdy = 1'b0;
        repeat (TIMEOUT - 1) tick();
        eng_done = 1'b1;
        eng_reject = 1'b1;
        tick();
        eng_done = 1'b0;
        eng_reject = 1'b0;
        get_rsp(r);
        chk("done_in_timeout_cycle_rsp", r, {2'd1, 8'h45});

        // back-to-back pushes with a stalled consumer: skid, overflow, egress fills to OUT_N
        eng_rdy = 1'b1;
        eng_done = 1'b1;
        first_full = -1;
        for (int i = 0; i < 24; i++) begin
            push(mk(1, i, 1, 0));
            if (first_full < 0 && cmd_full_r === 1'b1) first_full = i;
        end
        chk("full_rise_index", first_full, 8);
        chk("overflow_set", err_overflow_r, 1'b1);
        chk("egress_head", rsp, {2'd0, 8'h00});
        for (int k = 0; k < 13; k++) begin
            get_rsp(r);
            chk("drain_order", r, {2'd0, UID_W'(exp_uid[k])});
        end
        repeat (10) tick();
        chk("drain_empty", rsp_vld, 1'b0);
        chk("overflow_sticky", err_overflow_r, 1'b1);
        eng_rdy = 1'b0;
        eng_done = 1'b0;

        // reset while waiting on the engine with a response already queued
        push(mk(0, 'h5A, 0, 0));
        repeat (3) tick();
        push(mk(1, 'h55, 3, 0));
        wait_eng();
        eng_rdy = 1'b1;
        tick();
        eng_rdy = 1'b0;
        repeat (3) tick();
        chk("pre_reset_rsp_vld", rsp_vld, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_eng_vld", eng_vld, 1'b0);
        chk("async_reset_rsp_vld", rsp_vld, 1'b0);
        chk("async_reset_cmd_full_r", cmd_full_r, 1'b0);
        chk("async_reset_err_overflow_r", err_overflow_r, 1'b0);
        tick();
        rst = 1'b1;
        saw_rsp = 0;
        eng_done = 1'b1;
        repeat (20) tick();
        eng_done = 1'b0;
        chk("no_stale_rsp", saw_rsp, 1'b0);

        // randomized traffic checked cycle by cycle against the model
        rsp_cnt = 0;
        for (int it = 0; it < 3000; it++) begin
            bit hot = (it / 500) % 2 == 0;
            cmd_vld = hot ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
            cmd = mk(2'($urandom % 4), int'($urandom % 256), ($urandom % 4 == 0) ? 0 : int'($urandom % 1024),
                     int'($urandom % 1024));
            eng_rdy = $urandom % 2 == 0;
            eng_done = $urandom % 8 == 0;
            eng_reject = $urandom % 2 == 0;
            rsp_accept = hot ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            if (rsp_vld === 1'b1 && rsp_accept) rsp_cnt++;
            if (it == 1500) begin
                #2 rst = 1'b0;
                #1 rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end
        chk("random_activity", rsp_cnt > 50, 1'b1);
        cmd_vld = 1'b0;
        rsp_accept = 1'b1;
        eng_rdy = 1'b1;
        eng_done = 1'b1;
        repeat (150) tick();
        chk("final_empty", rsp_vld, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
